// File: rtl/aqp_clk_pkg.sv
// Shared types and constants for the aq32 clock-enable generator.
// Rate constants assume the 28.63636 MHz system clock and 24-bit accumulators.
package aqp_clk_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_RUN       = 2'd2
  } seq_state_e;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // incr = f_out / f_clk * 2^24
  localparam logic [23:0] INCR_7M16   = 24'h400000;  // f_clk/4
  localparam logic [23:0] INCR_3M58   = 24'h200000;  // f_clk/8, NTSC colour burst
  localparam logic [23:0] INCR_1M79   = 24'h100000;  // f_clk/16
  localparam logic [23:0] INCR_115K2  = 24'h0107A6;  // 16x oversample base for 7.2 kbaud-class UART

endpackage

// File: rtl/aqp_clken_ch.sv
// One phase-accumulator channel: active/pending increment, enable, and
// carry-aligned application of pending writes so rate changes never glitch.
module aqp_clken_ch
  import aqp_clk_pkg::*;
#(
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_i,
  input  logic                 sync_i,
  input  logic                 wr_i,
  input  logic                 wr_en_i,
  input  logic [ACC_WIDTH-1:0] wr_incr_i,
  output logic                 clken_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d, incr_q, incr_d, pincr_q, pincr_d;
  logic                 en_q, en_d, pen_q, pen_d, pvld_q, pvld_d, clken_q, clken_d;
  logic [ACC_WIDTH:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, incr_q};
    acc_d   = acc_q;
    incr_d  = incr_q;
    en_d    = en_q;
    pincr_d = pincr_q;
    pen_d   = pen_q;
    pvld_d  = pvld_q;
    clken_d = 1'b0;
    if (!run_i || sync_i || !en_q) begin
      // Idle or realigning: no period is in flight, so a pending value is safe now.
      acc_d = '0;
      if (pvld_q) begin
        incr_d = pincr_q;
        en_d   = pen_q;
        pvld_d = 1'b0;
      end
    end else begin
      acc_d   = sum[ACC_WIDTH-1:0];
      clken_d = sum[ACC_WIDTH];
      if (sum[ACC_WIDTH] && pvld_q) begin
        incr_d = pincr_q;
        en_d   = pen_q;
        pvld_d = 1'b0;
        if (!pen_q) acc_d = '0;
      end
    end
    if (wr_i) begin
      if (run_i && en_q) begin
        pincr_d = wr_incr_i;
        pen_d   = wr_en_i;
        pvld_d  = 1'b1;
      end else begin
        incr_d = wr_incr_i;
        en_d   = wr_en_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      incr_q  <= '0;
      pincr_q <= '0;
      en_q    <= 1'b0;
      pen_q   <= 1'b0;
      pvld_q  <= 1'b0;
      clken_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      incr_q  <= incr_d;
      pincr_q <= pincr_d;
      en_q    <= en_d;
      pen_q   <= pen_d;
      pvld_q  <= pvld_d;
      clken_q <= clken_d;
    end
  end

  assign clken_o = clken_q;

endmodule

// File: rtl/aqp_clken_gen.sv
// Multi-channel clock-enable generator with PLL lock sequencer.
// Define AQP_CLKEN_PHASE_SYNC_EN to add the phase_sync alignment input.
module aqp_clken_gen
  import aqp_clk_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ACC_WIDTH   = 24,
  parameter int LOCK_WAIT   = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pll_locked,
`ifdef AQP_CLKEN_PHASE_SYNC_EN
  input  logic                          phase_sync,
`endif
  input  logic                          cfg_wr,
  input  logic [ch_width(NUM_CH)-1:0]   cfg_ch,
  input  logic                          cfg_en,
  input  logic [ACC_WIDTH-1:0]          cfg_incr,
  output logic [NUM_CH-1:0]             ch_clken,
  output logic                          sys_reset,
  output logic                          ready
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int CNT_W = $clog2(LOCK_WAIT) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sys_reset_q, ready_q;
  logic                   run, psync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end
  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT_LOCK:
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = CNT_W'(1);
        end
      ST_STABLE:
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_WAIT - 1)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      ST_RUN:
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_reset_q <= (state_d != ST_RUN);
      ready_q     <= (state_d == ST_RUN);
    end
  end

  // Channels count only while staying in RUN, so lock loss clears them on the same edge.
  assign run = (state_q == ST_RUN) && (state_d == ST_RUN);

`ifdef AQP_CLKEN_PHASE_SYNC_EN
  assign psync = phase_sync && (state_q == ST_RUN);
`else
  assign psync = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    aqp_clken_ch #(.ACC_WIDTH(ACC_WIDTH)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .run_i     (run),
      .sync_i    (psync),
      .wr_i      (cfg_wr && (cfg_ch == CH_W'(i))),
      .wr_en_i   (cfg_en),
      .wr_incr_i (cfg_incr),
      .clken_o   (ch_clken[i])
    );
  end

  assign sys_reset = sys_reset_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_aqp_clken_gen.sv
// Self-checking bench for aqp_clken_gen: directed lock/rate sequences plus
// randomized traffic against a cycle-level reference model.
module tb_aqp_clken_gen;

  localparam int NUM_CH = 3;
  localparam int AW     = 24;
  localparam int LW     = 16;
  localparam int SS     = 2;
  localparam longint MOD = 64'd1 << AW;

  logic              clk = 1'b0, reset = 1'b1, pll_locked = 1'b0;
  logic              cfg_wr = 1'b0, cfg_en = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [AW-1:0]     cfg_incr = '0;
  logic [NUM_CH-1:0] ch_clken;
  logic              sys_reset, ready;
`ifdef AQP_CLKEN_PHASE_SYNC_EN
  logic              phase_sync = 1'b0;
`endif

  aqp_clken_gen #(.NUM_CH(NUM_CH), .ACC_WIDTH(AW), .LOCK_WAIT(LW), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
`ifdef AQP_CLKEN_PHASE_SYNC_EN
    .phase_sync (phase_sync),
`endif
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_en     (cfg_en),
    .cfg_incr   (cfg_incr),
    .ch_clken   (ch_clken),
    .sys_reset  (sys_reset),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: lock is "stable" once LW consecutive synchronised samples are high.
  int                m_lq[$];
  int                m_streak;
  bit                m_run;
  longint            m_acc[NUM_CH], m_incr[NUM_CH], m_pincr[NUM_CH];
  bit                m_en[NUM_CH], m_pen[NUM_CH], m_pvld[NUM_CH];
  bit [NUM_CH-1:0]   m_clken;

  task automatic model_reset();
    m_lq.delete();
    m_streak = 0;
    m_run    = 0;
    m_clken  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i] = 0; m_incr[i] = 0; m_pincr[i] = 0;
      m_en[i] = 0; m_pen[i] = 0; m_pvld[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit lock_s, run_prev, active, sync, en_old;
    m_lq.push_back(int'(pll_locked));
    lock_s   = (m_lq.size() > SS) ? bit'(m_lq.pop_front()) : 1'b0;
    run_prev = m_run;
    m_streak = lock_s ? m_streak + 1 : 0;
    m_run    = (m_streak >= LW);
    active   = run_prev && m_run;
`ifdef AQP_CLKEN_PHASE_SYNC_EN
    sync = phase_sync && run_prev;
`else
    sync = 1'b0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      en_old = m_en[i];
      if (!active || sync || !m_en[i]) begin
        m_acc[i] = 0;
        m_clken[i] = 1'b0;
        if (m_pvld[i]) begin m_incr[i] = m_pincr[i]; m_en[i] = m_pen[i]; m_pvld[i] = 0; end
      end else begin
        m_acc[i] += m_incr[i];
        m_clken[i] = (m_acc[i] >= MOD);
        m_acc[i] = m_acc[i] % MOD;
        if (m_clken[i] && m_pvld[i]) begin
          m_incr[i] = m_pincr[i]; m_en[i] = m_pen[i]; m_pvld[i] = 0;
          if (!m_en[i]) m_acc[i] = 0;
        end
      end
      if (cfg_wr && int'(cfg_ch) == i) begin
        if (active && en_old) begin
          m_pincr[i] = longint'(cfg_incr); m_pen[i] = cfg_en; m_pvld[i] = 1;
        end else begin
          m_incr[i] = longint'(cfg_incr); m_en[i] = cfg_en;
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_clken", 32'(ch_clken), 32'(m_clken));
    chk("model_sys_reset", 32'(sys_reset), 32'(!m_run));
    chk("model_ready", 32'(ready), 32'(m_run));
  endtask

  task automatic write(input int ch, input bit en, input logic [AW-1:0] incr);
    cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_en = en; cfg_incr = incr;
    step();
    cfg_wr = 1'b0;
  endtask

  typedef struct {
    int n;
    bit pll;
    bit exp_rst;
    bit exp_rdy;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int n, lowcnt;
    // power-up, then lock loss, glitch at counter=10, and full relock
    tbl[0] = '{17, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{3,  1'b1, 1'b0, 1'b1};
    tbl[2] = '{2,  1'b0, 1'b0, 1'b1};
    tbl[3] = '{2,  1'b0, 1'b1, 1'b0};
    tbl[4] = '{10, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1,  1'b0, 1'b1, 1'b0};
    tbl[6] = '{17, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{3,  1'b1, 1'b0, 1'b1};

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_clken", 32'(ch_clken), 0);
    chk("reset_sys_reset", 32'(sys_reset), 1);
    chk("reset_ready", 32'(ready), 0);
    pll_locked = 1'b1;
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      pll_locked = tbl[v].pll;
      for (int c = 0; c < tbl[v].n; c++) begin
        step();
        chk($sformatf("seq%0d_sys_reset", v), 32'(sys_reset), 32'(tbl[v].exp_rst));
        chk($sformatf("seq%0d_ready", v), 32'(ready), 32'(tbl[v].exp_rdy));
        chk($sformatf("seq%0d_clken", v), 32'(ch_clken), 0);
      end
    end

    // ch0 at f/4: first pulse on the 4th cycle after the write lands
    write(0, 1'b1, 24'h400000);
    chk("p4_c1", 32'(ch_clken[0]), 0);
    for (int c = 2; c <= 13; c++) begin
      step();
      chk($sformatf("p4_c%0d", c), 32'(ch_clken[0]), 32'(c >= 5 && (c - 5) % 4 == 0));
    end

    // two writes before the next carry: last wins, switch exactly at the carry
    write(0, 1'b1, 24'h200000);
    chk("lww_c14", 32'(ch_clken[0]), 0);
    write(0, 1'b1, 24'h800000);
    chk("lww_c15", 32'(ch_clken[0]), 0);
    for (int c = 16; c <= 23; c++) begin
      step();
      chk($sformatf("lww_c%0d", c), 32'(ch_clken[0]), 32'(c >= 17 && (c % 2) == 1));
    end

    // lock loss with ch1 at 0x555555, then relock resumes from acc=0
    write(1, 1'b1, 24'h555555);
    repeat (12) step();
    pll_locked = 1'b0;
    step(); step();
    chk("loss_ready_held", 32'(ready), 1);
    step();
    chk("loss_clken", 32'(ch_clken), 0);
    chk("loss_sys_reset", 32'(sys_reset), 1);
    pll_locked = 1'b1;
    n = 0;
    while (!ready && n < 40) begin step(); n++; end
    chk("relock_cycles", 32'(n), 18);
    n = 0;
    do begin step(); n++; end while (!ch_clken[1] && n < 10);
    chk("relock_ch1_first", 32'(n), 4);

    // out-of-range channel index is ignored
    write(3, 1'b1, 24'hFFFFFF);
    repeat (8) step();

`ifdef AQP_CLKEN_PHASE_SYNC_EN
    write(0, 1'b1, 24'h400000);
    write(1, 1'b1, 24'h200000);
    repeat (12) step();
    phase_sync = 1'b1;
    step();
    phase_sync = 1'b0;
    chk("psync_clken", 32'(ch_clken), 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("psync_ch0_k%0d", k), 32'(ch_clken[0]), 32'(k % 4 == 0));
      chk($sformatf("psync_ch1_k%0d", k), 32'(ch_clken[1]), 32'(k % 8 == 0));
    end
`endif

    lowcnt = 0;
    for (int c = 0; c < 4000; c++) begin
      if (lowcnt == 0 && $urandom_range(0, 299) == 0) lowcnt = $urandom_range(1, 5);
      pll_locked = (lowcnt == 0);
      if (lowcnt > 0) lowcnt--;
      cfg_wr = ($urandom_range(0, 5) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_en = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 5))
        0: cfg_incr = 24'h000000;
        1: cfg_incr = 24'h400000;
        2: cfg_incr = 24'h200000;
        3: cfg_incr = 24'h555555;
        4: cfg_incr = 24'hFFFFFF;
        default: cfg_incr = 24'($urandom);
      endcase
`ifdef AQP_CLKEN_PHASE_SYNC_EN
      phase_sync = ($urandom_range(0, 99) == 0);
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aqp_clken_gen.md
Name: aqp_clken_gen

Overview:
- Parametrised multi-channel clock-enable generator for the aq32 system clock domain (28.63636 MHz).
- Each channel has a phase accumulator that produces fractional-rate single-cycle enables (CPU, audio, UART, timers) from one clock.
- Rate changes are glitch-free.
- An integrated lock/reset sequencer holds the system in reset until the PLL lock has been stable for a set time.

Parameters:
- NUM_CH, 4, number of clock-enable channels (1..16).
- ACC_WIDTH, 24, phase accumulator/increment width in bits.
- LOCK_WAIT, 1024, consecutive synchronised-lock cycles required before reset release (>=2).
- SYNC_STAGES, 2, flip-flop stages on the asynchronous pll_locked input (>=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pll_locked  in  1  asynchronous lock indication from the PLL.
- cfg_wr  in  1  single-cycle configuration write strobe.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel for the write.
- cfg_en  in  1  channel enable value to write.
- cfg_incr  in  ACC_WIDTH  phase increment to write.
- ch_clken  out  NUM_CH  per-channel single-cycle enable pulses.
- sys_reset  out  1  synchronous system reset (high until the lock is stable).
- ready  out  1  high when in RUN.

Behaviour:
- Reset values:
  - ch_clken=0, sys_reset=1, ready=0.
  - All accumulators, active and pending increments, enables and pending flags = 0.
  - Lock counter = 0; state = WAIT_LOCK.
- Lock synchroniser: pll_locked passes through SYNC_STAGES flops, giving lock_s.
- State machine:
  - WAIT_LOCK: when lock_s=1, go to STABLE with counter=1.
  - STABLE: if lock_s=0, go to WAIT_LOCK (counter=0). Otherwise increment the counter; at counter==LOCK_WAIT-1 with lock_s=1, go to RUN.
  - RUN: if lock_s=0, go to WAIT_LOCK.
- Outputs per state:
  - sys_reset=1 and ready=0 in every state except RUN; both registered.
  - With pll_locked held high from reset release, sys_reset falls on edge SYNC_STAGES+LOCK_WAIT.
- Channel i, in RUN with en_i=1:
  - Each cycle: {carry, acc_i} <= acc_i + incr_i, using ACC_WIDTH+1 bit arithmetic with wrap-around.
  - ch_clken[i] <= carry (registered, one-cycle pulse).
  - Output rate = f_clk * incr_i / 2^ACC_WIDTH.
  - incr_i=0 means no pulses.
- Outside RUN, or when en_i=0: acc_i held at 0, ch_clken[i]=0.
- Leaving RUN (lock loss) clears all accumulators and ch_clken on the same edge. Configuration (incr, en, pending) is retained.
- Configuration writes (accepted in any state):
  - cfg_ch >= NUM_CH: write ignored.
  - Target channel disabled or not in RUN: incr/en applied on the next edge.
  - Target channel enabled and in RUN: value stored as pending. It is applied on the first cycle whose accumulator update produces carry=1; the new incr is used from the following cycle, with no short or long period.
  - A second write before the pending value is applied overwrites it (last write wins).
  - A pending write with cfg_en=0 disables the channel at that carry.
  - A pending value never applies mid-period.
- Simultaneous events:
  - Lock loss and pending apply in the same cycle: lock loss wins; the pending value is applied immediately, because the channel is no longer in RUN.
  - cfg_wr to the same channel in the cycle its pending value applies: the new write becomes pending.

Optional Feature:
- AQP_CLKEN_PHASE_SYNC_EN defined:
  - Adds input port phase_sync (1 bit).
  - A phase_sync=1 pulse in RUN zeroes all accumulators on the next edge and applies all pending values immediately, phase-aligning every channel.
  - ch_clken is 0 in that cycle.
- Undefined: no phase_sync port and no alignment logic.

Decomposition:
- Shared package aqp_clk_pkg:
  - State encoding (WAIT_LOCK, STABLE, RUN).
  - Channel-index width function.
  - Default increment constants for the standard rates, e.g. 3.579545 MHz = 2^24/8 at 28.63636 MHz.
- Sub-module aqp_clken_ch: one instance per channel, holding the accumulator, active/pending increment, enable and carry-apply logic.
- Top level: synchroniser, sequencer and configuration decode.

Test Plan:
- Power-up, LOCK_WAIT=16, SYNC_STAGES=2, pll_locked=1 -> sys_reset falls and ready rises on edge 18 after reset release; ch_clken stays 0 throughout.
- pll_locked glitches low 1 cycle at counter=10 in STABLE -> returns to WAIT_LOCK; sys_reset held; full 16 stable cycles required again.
- In RUN, ch0 incr=0x400000 (ACC_WIDTH=24), en=1 -> ch_clken[0] pulses every 4th cycle, the first on the 4th cycle after the write is applied; pulses are exactly 1 cycle wide.
- ch0 running at 0x400000; write incr=0x200000 mid-period, then 0x800000 before the next carry -> no change until the carry, then pulses every 2nd cycle (last write wins); no shortened interval.
- Lock loss in RUN with ch1 incr=0x555555 -> next edge: ch_clken=0, sys_reset=1, acc cleared; after relock, ch1 resumes with the same incr from acc=0.
- AQP_CLKEN_PHASE_SYNC_EN: ch0=0x400000, ch1=0x200000, offset phases; pulse phase_sync -> both accumulators 0; ch0 pulses 4 cycles later and ch1 pulses 8 cycles later, coincident every 8 cycles.
